// File: rtl/trace_chk_pkg.sv
// Shared definitions for the instruction trace checker: FSM state encoding
// and default parameter values used by instr_trace_checker and trace_exp_mem.
package trace_chk_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } trace_state_t;

   localparam int TRACE_INSTR_W    = 16;
   localparam int TRACE_PC_W       = 16;
   localparam int TRACE_DEPTH      = 16;
   localparam int TRACE_MAX_CHECKS = 15;
   localparam int TRACE_CNT_W      = 8;

   // Instructions are 2 bytes wide, so the table index is the PC shifted by one.
   localparam int PC_STEP_SHIFT    = 1;

endpackage

// File: rtl/trace_exp_mem.sv
// Expected-instruction table for the trace checker. Data words live in a
// plain array (no reset needed); each entry has a valid bit that is cleared
// by rst and set when the entry is written. Read is combinational.
module trace_exp_mem
   import trace_chk_pkg::*;
#(
   parameter int INSTR_W = TRACE_INSTR_W,
   parameter int DEPTH   = TRACE_DEPTH,
   parameter int AW      = $clog2(DEPTH)
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic [AW-1:0]      wr_addr,
   input  logic [INSTR_W-1:0] wr_data,
   input  logic [AW-1:0]      rd_addr,
   output logic [INSTR_W-1:0] rd_data,
   output logic               rd_valid
);

   logic [INSTR_W-1:0] data_mem [DEPTH];
   logic [DEPTH-1:0]   valid_reg;
   logic [DEPTH-1:0]   valid_set;

   // One-hot decode of the write address into per-entry set strobes.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid_set
         assign valid_set[gi] = wr_en && (wr_addr == AW'(gi));
      end
   endgenerate

   // Table data write; contents survive reset and are only trusted via valid bits.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         data_mem[wr_addr] <= wr_data;
      end
   end

   // Valid bits: cleared on reset, set sticky on write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_reg <= '0;
      end else begin
         valid_reg <= valid_reg | valid_set;
      end
   end

   assign rd_data  = data_mem[rd_addr];
   assign rd_valid = valid_reg[rd_addr];

endmodule

// File: rtl/instr_trace_checker.sv
// Instruction trace checker: compares fetched (pc, instr) samples against a
// preloaded expected-instruction table during a run, counting checks and
// errors and capturing the first offending sample.
// Optional feature: define TRACE_CHK_STOP_ON_ERR_EN to end the run on the
// first error; otherwise the run continues until stop or MAX_CHECKS.
module instr_trace_checker
   import trace_chk_pkg::*;
#(
   parameter int INSTR_W    = TRACE_INSTR_W,
   parameter int PC_W       = TRACE_PC_W,
   parameter int DEPTH      = TRACE_DEPTH,
   parameter int MAX_CHECKS = TRACE_MAX_CHECKS,
   parameter int CNT_W      = TRACE_CNT_W
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     load_en,
   input  logic [$clog2(DEPTH)-1:0] load_addr,
   input  logic [INSTR_W-1:0]       load_data,
   input  logic                     start,
   input  logic                     stop,
   input  logic                     mon_valid,
   input  logic [PC_W-1:0]          mon_pc,
   input  logic [INSTR_W-1:0]       mon_instr,
   output logic                     busy,
   output logic                     done,
   output logic                     pass,
   output logic                     err_pulse,
   output logic [CNT_W-1:0]         check_cnt,
   output logic [CNT_W-1:0]         err_cnt,
   output logic [PC_W-1:0]          first_err_pc,
   output logic [INSTR_W-1:0]       first_err_instr
);

   localparam int              AW      = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] MAX_CHK = CNT_W'(MAX_CHECKS);

   trace_state_t       state_reg;

   logic [PC_W-1:0]    idx_full;
   logic               in_range;
   logic [AW-1:0]      rd_addr;
   logic [INSTR_W-1:0] rd_data;
   logic               rd_valid;
   logic               table_wr;

   logic               sample_take;
   logic               sample_err;
   logic [CNT_W-1:0]   check_cnt_next;
   logic [CNT_W-1:0]   err_cnt_next;
   logic               err_stop;
   logic               run_end;
   logic               pass_on_end;

   // Table index from the PC; anything beyond the table is an error by itself.
   assign idx_full = mon_pc >> PC_STEP_SHIFT;
   assign in_range = (idx_full < PC_W'(DEPTH));
   assign rd_addr  = idx_full[AW-1:0];

   // The table can only be rewritten while no run is in progress or finished.
   assign table_wr = load_en && (state_reg == ST_IDLE);

   trace_exp_mem #(
      .INSTR_W (INSTR_W),
      .DEPTH   (DEPTH),
      .AW      (AW)
   ) u_exp_mem (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (table_wr),
      .wr_addr  (load_addr),
      .wr_data  (load_data),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_valid (rd_valid)
   );

   assign sample_take = mon_valid && (state_reg == ST_RUN);
   assign sample_err  = !in_range || !rd_valid || (mon_instr != rd_data);

   // Saturating increments: counters stick at all-ones instead of wrapping.
   assign check_cnt_next = (check_cnt == CNT_MAX) ? check_cnt : check_cnt + 1'b1;
   assign err_cnt_next   = (err_cnt == CNT_MAX) ? err_cnt : err_cnt + 1'b1;

`ifdef TRACE_CHK_STOP_ON_ERR_EN
   assign err_stop = sample_take && sample_err;
`else
   assign err_stop = 1'b0;
`endif

   // A sample taken in the same cycle as stop is still counted before the run ends.
   assign run_end = stop || (sample_take && (check_cnt_next == MAX_CHK)) || err_stop;

   // Pass verdict must reflect the sample being retired in the ending cycle.
   assign pass_on_end = (err_cnt == '0) && !(sample_take && sample_err) &&
                        ((check_cnt != '0) || sample_take);

   // Run-control FSM with all outputs registered alongside the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= ST_IDLE;
         busy            <= 1'b0;
         done            <= 1'b0;
         pass            <= 1'b0;
         err_pulse       <= 1'b0;
         check_cnt       <= '0;
         err_cnt         <= '0;
         first_err_pc    <= '0;
         first_err_instr <= '0;
      end else begin
         err_pulse <= 1'b0;
         case (state_reg)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state_reg       <= ST_RUN;
                  busy            <= 1'b1;
                  done            <= 1'b0;
                  pass            <= 1'b0;
                  check_cnt       <= '0;
                  err_cnt         <= '0;
                  first_err_pc    <= '0;
                  first_err_instr <= '0;
               end
            end
            ST_RUN: begin
               if (sample_take) begin
                  check_cnt <= check_cnt_next;
                  if (sample_err) begin
                     err_pulse <= 1'b1;
                     err_cnt   <= err_cnt_next;
                     if (err_cnt == '0) begin
                        first_err_pc    <= mon_pc;
                        first_err_instr <= mon_instr;
                     end
                  end
               end
               if (run_end) begin
                  state_reg <= ST_DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  pass      <= pass_on_end;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
               busy      <= 1'b0;
               done      <= 1'b0;
            end
         endcase
      end
   end

endmodule
